// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster counters with a registered DAC colour/sync/blank stage
// and a once-per-frame pulse at the start of vertical blanking.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_en,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic [7:0] o_vga_r,
  output logic [7:0] o_vga_g,
  output logic [7:0] o_vga_b,
  output logic       o_vga_hs,
  output logic       o_vga_vs,
  output logic       o_vga_blank_n,
  output logic       o_vga_sync_n,
  output logic       o_frame_pulse
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_W   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS_W    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE_W    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST_W  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_W   = 10'(V_ACTIVE);
  localparam logic [9:0] V_ALAST_W = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_SS_W    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE_W    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST_W  = 10'(V_TOTAL - 1);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic [7:0] r_q, g_q, b_q;
  logic       hs_q, vs_q, blank_n_q, frame_q;
  logic       active, hs0, vs0, h_wrap, frame_d;

  always_comb begin
    h_wrap  = (hc_q == H_LAST_W);
    hc_d    = h_wrap ? 10'd0 : hc_q + 10'd1;
    vc_d    = vc_q;
    if (h_wrap) begin
      vc_d = (vc_q == V_LAST_W) ? 10'd0 : vc_q + 10'd1;
    end
    active  = (hc_q < H_ACT_W) && (vc_q < V_ACT_W);
    hs0     = !((hc_q >= H_SS_W) && (hc_q <= H_SE_W));
    vs0     = !((vc_q >= V_SS_W) && (vc_q <= V_SE_W));
    // Last strobe of the last visible line: next state enters vertical blanking.
    frame_d = h_wrap && (vc_q == V_ALAST_W);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hc_q      <= 10'd0;
      vc_q      <= 10'd0;
      r_q       <= 8'd0;
      g_q       <= 8'd0;
      b_q       <= 8'd0;
      blank_n_q <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      if (i_pix_en) begin
        hc_q      <= hc_d;
        vc_q      <= vc_d;
        r_q       <= active ? i_r : 8'd0;
        g_q       <= active ? i_g : 8'd0;
        b_q       <= active ? i_b : 8'd0;
        blank_n_q <= active;
        hs_q      <= hs0;
        vs_q      <= vs0;
        frame_q   <= frame_d;
      end
    end
  end

  assign o_x           = hc_q;
  assign o_y           = vc_q;
  assign o_vga_r       = r_q;
  assign o_vga_g       = g_q;
  assign o_vga_b       = b_q;
  assign o_vga_hs      = hs_q;
  assign o_vga_vs      = vs_q;
  assign o_vga_blank_n = blank_n_q;
  assign o_vga_sync_n  = 1'b0;
  assign o_frame_pulse = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen on a reduced 15x8 raster
// (active 8x4, hsync at hc 10..12, vsync at vc 5..6, frame pulse entering (0,4)).
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_en;
  logic [9:0] o_x, o_y;
  logic [7:0] i_r, i_g, i_b;
  logic [7:0] o_r, o_g, o_b;
  logic       o_hs, o_vs, o_blank_n, o_sync_n, o_fp;

  int total = 0;
  int bad   = 0;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
    .o_x(o_x), .o_y(o_y),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_vga_r(o_r), .o_vga_g(o_g), .o_vga_b(o_b),
    .o_vga_hs(o_hs), .o_vga_vs(o_vs),
    .o_vga_blank_n(o_blank_n), .o_vga_sync_n(o_sync_n),
    .o_frame_pulse(o_fp)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    total++;
    if ({o_x, o_y, o_r, o_g, o_b, o_blank_n, o_hs, o_vs, o_fp, o_sync_n} !==
        {10'd0, 10'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL %s got x=%0d y=%0d rgb=%h%h%h bn=%b hs=%b vs=%b fp=%b sn=%b want x=0 y=0 rgb=000000 bn=0 hs=1 vs=1 fp=0 sn=0",
               tag, o_x, o_y, o_r, o_g, o_b, o_blank_n, o_hs, o_vs, o_fp, o_sync_n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; pix_en = 1'b0;
    tick; tick;
    check_reset_vals("reset_state");
  endtask

  task automatic test_full_frame;
    logic [9:0] ex, ey, px, py;
    logic       act, ehs, evs, efp;
    int hs_low = 0, vs_low = 0, bn_hi = 0, pulses = 0;
    rst = 1'b1; pix_en = 1'b1; tick;
    rst = 1'b0;
    ex = 0; ey = 0;
    for (int k = 1; k <= 120; k++) begin
      px = ex; py = ey;
      ex = ex + 10'd1;
      if (ex == 10'd15) begin
        ex = 0;
        ey = (ey == 10'd7) ? 10'd0 : ey + 10'd1;
      end
      tick;
      act = (px < 10'd8) && (py < 10'd4);
      ehs = !((px >= 10'd10) && (px <= 10'd12));
      evs = !((py >= 10'd5) && (py <= 10'd6));
      efp = (ex == 10'd0) && (ey == 10'd4);
      total++;
      if ({o_x, o_y} !== {ex, ey}) begin
        bad++; $display("FAIL frame_coord k=%0d got (%0d,%0d) want (%0d,%0d)", k, o_x, o_y, ex, ey);
      end
      total++;
      if ({o_blank_n, o_hs, o_vs} !== {act, ehs, evs}) begin
        bad++; $display("FAIL frame_sync k=%0d got bn/hs/vs=%b%b%b want %b%b%b", k, o_blank_n, o_hs, o_vs, act, ehs, evs);
      end
      total++;
      if ({o_r, o_g, o_b} !== (act ? 24'hAA55C3 : 24'h0)) begin
        bad++; $display("FAIL frame_rgb k=%0d got %h%h%h want %h", k, o_r, o_g, o_b, act ? 24'hAA55C3 : 24'h0);
      end
      total++;
      if (o_fp !== efp) begin
        bad++; $display("FAIL frame_pulse k=%0d got %b want %b", k, o_fp, efp);
      end
      if (!o_hs) hs_low++;
      if (!o_vs) vs_low++;
      if (o_blank_n) bn_hi++;
      if (o_fp) pulses++;
    end
    total++;
    if (hs_low != 24) begin bad++; $display("FAIL hs_low_count got %0d want 24", hs_low); end
    total++;
    if (vs_low != 30) begin bad++; $display("FAIL vs_low_count got %0d want 30", vs_low); end
    total++;
    if (bn_hi != 32) begin bad++; $display("FAIL blank_hi_count got %0d want 32", bn_hi); end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL pulse_count got %0d want 1", pulses); end
  endtask

  task automatic test_half_rate;
    logic [9:0] ex, ey;
    logic [50:0] snap;
    int pulses = 0;
    rst = 1'b1; pix_en = 1'b1; tick;
    rst = 1'b0;
    ex = 0; ey = 0;
    for (int c = 0; c < 240; c++) begin
      pix_en = (c % 2 == 0);
      snap = {o_x, o_y, o_r, o_g, o_b, o_blank_n, o_hs, o_vs};
      if (pix_en) begin
        ex = ex + 10'd1;
        if (ex == 10'd15) begin
          ex = 0;
          ey = (ey == 10'd7) ? 10'd0 : ey + 10'd1;
        end
      end
      tick;
      if (pix_en) begin
        total++;
        if ({o_x, o_y, o_fp} !== {ex, ey, (ex == 10'd0) && (ey == 10'd4)}) begin
          bad++; $display("FAIL half_strobe c=%0d got (%0d,%0d) fp=%b want (%0d,%0d)", c, o_x, o_y, o_fp, ex, ey);
        end
      end else begin
        total++;
        if ({o_x, o_y, o_r, o_g, o_b, o_blank_n, o_hs, o_vs, o_fp} !== {snap, 1'b0}) begin
          bad++; $display("FAIL half_hold c=%0d got %h fp=%b want %h fp=0", c,
                          {o_x, o_y, o_r, o_g, o_b, o_blank_n, o_hs, o_vs}, o_fp, snap);
        end
      end
      if (o_fp) pulses++;
    end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL half_pulse_count got %0d want 1", pulses); end
  endtask

  task automatic test_mid_reset;
    int pulses = 0;
    rst = 1'b1; pix_en = 1'b1; tick;
    rst = 1'b0;
    for (int k = 0; k < 33; k++) tick;
    total++;
    if ({o_x, o_y} !== {10'd3, 10'd2}) begin
      bad++; $display("FAIL mid_position got (%0d,%0d) want (3,2)", o_x, o_y);
    end
    rst = 1'b1; tick;
    check_reset_vals("mid_reset");
    rst = 1'b0;
    for (int k = 0; k < 59; k++) begin
      tick;
      if (o_fp) pulses++;
    end
    total++;
    if (pulses != 0 || {o_x, o_y} !== {10'd14, 10'd3}) begin
      bad++; $display("FAIL mid_no_pulse got pulses=%0d at (%0d,%0d) want 0 at (14,3)", pulses, o_x, o_y);
    end
    tick;
    total++;
    if ({o_fp, o_x, o_y} !== {1'b1, 10'd0, 10'd4}) begin
      bad++; $display("FAIL mid_pulse got fp=%b (%0d,%0d) want fp=1 (0,4)", o_fp, o_x, o_y);
    end
    tick;
    total++;
    if (o_fp !== 1'b0) begin bad++; $display("FAIL mid_pulse_width got fp=%b want 0", o_fp); end
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0;
    i_r = 8'hAA; i_g = 8'h55; i_b = 8'hC3;
    test_reset;
    test_full_frame;
    test_half_rate;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing source for the VGA output path. Sweeps a 640x480@60 raster and presents the current pixel coordinate to the board renderer (`Game`) on `o_x`/`o_y`. Samples the renderer's combinational colour answer and drives the DAC colour, sync and blank pins, all aligned through one register stage. Also pulses once per frame at the start of vertical blanking so game logic can update the block array without tearing.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync pulse width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync pulse width, in lines
- V_BP, 33, vertical back porch, in lines

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_pix_en  in  1  pixel-rate strobe (for example, every 2nd cycle of 50 MHz); all state advances only on cycles with i_pix_en=1
- o_x  out  10  current horizontal count (0..H_TOTAL-1), wired to renderer x
- o_y  out  10  current vertical count (0..V_TOTAL-1), wired to renderer y
- i_r, i_g, i_b  in  8 each  renderer colour for (o_x, o_y), combinational, same cycle
- o_vga_r, o_vga_g, o_vga_b  out  8 each  registered colour to the DAC
- o_vga_hs  out  1  horizontal sync, active-low
- o_vga_vs  out  1  vertical sync, active-low
- o_vga_blank_n  out  1  high during the active region
- o_vga_sync_n  out  1  constant 0 (no sync-on-green)
- o_frame_pulse  out  1  one-cycle pulse at start of vertical blanking

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Horizontal counter (hc):
  - Increments on each i_pix_en.
  - At H_TOTAL-1 it wraps to 0 and, in the same strobe, steps the vertical counter vc.
- Vertical counter (vc):
  - At V_TOTAL-1 it wraps to 0.
  - When hc=799 and vc=524, both counters wrap to 0 together.
- Coordinates: o_x = hc and o_y = vc, driven directly from the counter registers.
- Stage-0 decode, from the counters:
  - active = (hc < H_ACTIVE) && (vc < V_ACTIVE).
  - hs0 = !(hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]), i.e. low for 656..751.
  - vs0 = !(vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]), i.e. low for 490..491.
- Stage-1 registers, updated on i_pix_en:
  - o_vga_r/g/b <= active ? i_r/g/b : 0.
  - o_vga_blank_n <= active.
  - o_vga_hs <= hs0; o_vga_vs <= vs0.
- o_frame_pulse:
  - Set for exactly one i_clk cycle.
  - Fires on the i_pix_en cycle where the counters advance from (hc=799, vc=479) to (0, 480).
- Compare widths: all comparisons are 10-bit unsigned. Parameters must satisfy H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024.

## Timing
- Reset values (i_rst=1 at a clock edge, whatever i_pix_en is):
  - hc=0, vc=0.
  - o_vga_r/g/b=0, o_vga_blank_n=0.
  - o_vga_hs=1, o_vga_vs=1.
  - o_frame_pulse=0.
- Reset mid-frame: restarts the raster at (0,0) on the next edge. No partial pulse is emitted.
- Latency:
  - o_x/o_y change 1 i_clk after the i_pix_en edge.
  - Colour, sync and blank for a pixel appear 1 pixel strobe after that pixel's coordinate.
  - All DAC-side outputs therefore stay mutually aligned.
- i_pix_en=0: every register holds its value. o_frame_pulse is 0 on those cycles.
- i_pix_en tied to 1: the block runs one pixel per clock with identical behaviour.
- Renderer contract: i_r/g/b must settle within one i_clk of o_x/o_y changing. No handshake is used.

## Test plan
- Reset, then i_pix_en=1 continuously:
  - o_x counts 0..799 then wraps to 0.
  - o_y increments exactly at that wrap.
  - After 800*525 = 420000 strobes, o_x=0 and o_y=0 again.
- Sync pulses: o_vga_hs is low for exactly 96 strobes per line, with its first low strobe one strobe after hc=656. o_vga_vs is low for exactly 2 lines (1600 strobes).
- Colour gating with renderer stub i_r=i_g=i_b=8'hAA:
  - o_vga_r=AA only while o_vga_blank_n=1; 640 blank_n-high strobes per active line.
  - o_vga_r=0 while vc ≥ 480.
- Frame pulse:
  - Exactly one o_frame_pulse per 420000 strobes.
  - It is coincident with the counters moving to (0, 480), and is 1 clock wide.
- Strobe gating: with i_pix_en toggling every other clock, counts advance at half rate and no output changes on i_pix_en=0 cycles. Check the frame pulse stays 1 clock wide.
- Mid-frame reset: assert i_rst at (hc=300, vc=200) → next edge gives o_x=0, o_y=0, hs=vs=1, blank_n=0, rgb=0. No frame pulse until the next (0,480) transition.
